// File: rtl/traffic_pkg.sv
// Shared types for the intersection light controller:
// phase encoding, lamp vectors and phase sequencing helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  function automatic int phase_len(
    input phase_e p,
    input int     green,
    input int     yellow,
    input int     allred
  );
    int len;
    len = 0;
    case (p)
      NS_GREEN, EW_GREEN:   len = green;
      NS_YELLOW, EW_YELLOW: len = yellow;
      ALLRED_A, ALLRED_B:   len = allred;
      default:              len = 0;
    endcase
    return len;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = NS_GREEN;
    case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intersection_light_flash_gen.sv
// Half-period toggle generator for the maintenance flash;
// output starts on after a clear.
module flash_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic en_i,
  input  logic clr_i,
  output logic on_o
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         off_q, off_d;

  always_comb begin
    cnt_d = cnt_q;
    off_d = off_q;
    if (clr_i) begin
      cnt_d = '0;
      off_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        off_d = ~off_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    off_q <= off_d;
  end

  assign on_o = ~off_q;

endmodule

// File: rtl/intersection_light.sv
// Two-way intersection controller with pedestrian
// shortening and a maintenance flash mode.
module intersection_light
  import traffic_pkg::*;
#(
  parameter int GREEN_LEN  = 60,
  parameter int YELLOW_LEN = 5,
  parameter int ALLRED_LEN = 2,
  parameter int PED_MAX    = 10,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ped_req,
  input  logic             flash_en,
  output logic [2:0]       ns_rgy,
  output logic [2:0]       ew_rgy,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (GREEN_LEN < 2) begin : g_bad_green
    $fatal(1, "GREEN_LEN must be >= 2");
  end
  if (YELLOW_LEN < 1) begin : g_bad_yellow
    $fatal(1, "YELLOW_LEN must be >= 1");
  end
  if (ALLRED_LEN < 1) begin : g_bad_allred
    $fatal(1, "ALLRED_LEN must be >= 1");
  end
  if (PED_MAX < 1 || PED_MAX >= GREEN_LEN) begin : g_bad_ped
    $fatal(1, "PED_MAX must satisfy 1 <= PED_MAX < GREEN_LEN");
  end
  if (FLASH_HALF < 1) begin : g_bad_flash
    $fatal(1, "FLASH_HALF must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cntw
    $fatal(1, "CNT_W must be in 1..31");
  end
  if (longint'(GREEN_LEN) > CNT_MAX ||
      longint'(YELLOW_LEN) > CNT_MAX ||
      longint'(ALLRED_LEN) > CNT_MAX) begin : g_bad_fit
    $fatal(1, "CNT_W too narrow for phase lengths");
  end

  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_LEN);
  localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_LEN);
  localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  phase_e           phase_q, phase_d, nxt;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       pend_q, pend_d;
  logic             ns_g, ew_g, shorten;
  logic             in_flash, flash_on;

  assign in_flash = (phase_q == FLASH);

  flash_gen #(
    .HALF (FLASH_HALF)
  ) u_flash (
    .clk   (clk),
    .en_i  (in_flash),
    .clr_i (rst | ~in_flash),
    .on_o  (flash_on)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= NS_GREEN;
      rem_q   <= GREEN_C;
      pend_q  <= '0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    nxt     = next_phase(phase_q);
    ns_g    = (phase_q == NS_GREEN);
    ew_g    = (phase_q == EW_GREEN);
    shorten = ((ns_g && ped_req[0]) || (ew_g && ped_req[1]))
              && (rem_q > PED_C);
    if (in_flash) begin
      pend_d = '0;
      if (!flash_en) begin
        phase_d = ALLRED_B;
        rem_d   = ALLRED_C;
      end
    end else if (flash_en) begin
      phase_d = FLASH;
      rem_d   = '0;
      pend_d  = '0;
    end else begin
      if (ped_req[0] && !ns_g) pend_d[0] = 1'b1;
      if (ped_req[1] && !ew_g) pend_d[1] = 1'b1;
      if (rem_q == ONE_C) begin
        phase_d = nxt;
        rem_d   = CNT_W'(phase_len(nxt, GREEN_LEN,
                                   YELLOW_LEN, ALLRED_LEN));
        // a request landing on the entry edge is already in pend_d
        if (nxt == NS_GREEN && pend_d[0]) begin
          rem_d     = PED_C;
          pend_d[0] = 1'b0;
        end
        if (nxt == EW_GREEN && pend_d[1]) begin
          rem_d     = PED_C;
          pend_d[1] = 1'b0;
        end
      end else if (shorten) begin
        rem_d = PED_C;
      end else begin
        rem_d = rem_q - ONE_C;
      end
    end
  end

  always_comb begin
    ns_rgy = LAMP_RED;
    ew_rgy = LAMP_RED;
    unique case (phase_q)
      NS_GREEN:  ns_rgy = LAMP_GRN;
      NS_YELLOW: ns_rgy = LAMP_YEL;
      EW_GREEN:  ew_rgy = LAMP_GRN;
      EW_YELLOW: ew_rgy = LAMP_YEL;
      FLASH: begin
        ns_rgy = flash_on ? LAMP_YEL : LAMP_OFF;
        ew_rgy = flash_on ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign countdown = rem_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_intersection_light.sv
// Bench for intersection_light: table of multi-cycle vectors
// plus a cycle-by-cycle reference model feeding a scoreboard.
module tb_intersection_light;
  import traffic_pkg::*;

  localparam int GL = 60;
  localparam int YL = 5;
  localparam int AL = 2;
  localparam int PM = 10;
  localparam int FH = 4;
  localparam int CW = 8;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ped_req;
  logic          flash_en;
  logic [2:0]    ns_rgy, ew_rgy, phase;
  logic [CW-1:0] countdown;

  intersection_light #(
    .GREEN_LEN  (GL),
    .YELLOW_LEN (YL),
    .ALLRED_LEN (AL),
    .PED_MAX    (PM),
    .FLASH_HALF (FH),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ped_req   (ped_req),
    .flash_en  (flash_en),
    .ns_rgy    (ns_rgy),
    .ew_rgy    (ew_rgy),
    .countdown (countdown),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    int         cd;
    logic [2:0] ph;
  } exp_t;

  typedef struct {
    string      name;
    bit         r;
    logic [1:0] p;
    bit         f;
    int         n;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  phase_e     m_ph;
  int         m_rem;
  logic [1:0] m_pend;
  int         m_fc;

  function automatic vec_t mk(string nm, bit r, logic [1:0] p,
                              bit f, int n, logic [2:0] ns,
                              logic [2:0] ew, int cd, phase_e ph);
    vec_t v;
    v.name = nm; v.r = r; v.p = p; v.f = f; v.n = n;
    v.e.ns = ns; v.e.ew = ew; v.e.cd = cd; v.e.ph = ph;
    return v;
  endfunction

  function automatic exp_t dut_out();
    exp_t a;
    a.ns = ns_rgy; a.ew = ew_rgy;
    a.cd = int'(countdown); a.ph = phase;
    return a;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ns = R; e.ew = R; e.cd = m_rem; e.ph = m_ph;
    case (m_ph)
      NS_GREEN:  e.ns = G;
      NS_YELLOW: e.ns = Y;
      EW_GREEN:  e.ew = G;
      EW_YELLOW: e.ew = Y;
      FLASH: begin
        e.ns = ((m_fc / FH) % 2 == 0) ? Y : O;
        e.ew = e.ns;
        e.cd = 0;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step(bit r, logic [1:0] p, bit f);
    int         g;
    bit         sh;
    logic [1:0] np;
    if (r) begin
      m_ph = NS_GREEN; m_rem = GL; m_pend = 0; m_fc = 0;
    end else if (m_ph == FLASH) begin
      m_pend = 0;
      if (f) m_fc++;
      else begin m_ph = ALLRED_B; m_rem = AL; m_fc = 0; end
    end else if (f) begin
      m_ph = FLASH; m_rem = 0; m_pend = 0; m_fc = 0;
    end else begin
      g  = (m_ph == NS_GREEN) ? 0 : (m_ph == EW_GREEN) ? 1 : -1;
      np = m_pend;
      sh = 0;
      for (int d = 0; d < 2; d++)
        if (p[d]) begin
          if (d == g) sh = (m_rem > PM);
          else np[d] = 1'b1;
        end
      if (m_rem == 1) begin
        case (m_ph)
          NS_GREEN:  begin m_ph = NS_YELLOW; m_rem = YL; end
          NS_YELLOW: begin m_ph = ALLRED_A;  m_rem = AL; end
          ALLRED_A: begin
            m_ph = EW_GREEN; m_rem = np[1] ? PM : GL; np[1] = 0;
          end
          EW_GREEN:  begin m_ph = EW_YELLOW; m_rem = YL; end
          EW_YELLOW: begin m_ph = ALLRED_B;  m_rem = AL; end
          default: begin
            m_ph = NS_GREEN; m_rem = np[0] ? PM : GL; np[0] = 0;
          end
        endcase
      end else begin
        m_rem = sh ? PM : m_rem - 1;
      end
      m_pend = np;
    end
  endtask

  task automatic cmp(string nm, exp_t a, exp_t e);
    checks++;
    if (a.ns !== e.ns || a.ew !== e.ew ||
        a.cd != e.cd || a.ph !== e.ph) begin
      errors++;
      $display("FAIL %s t=%0t: got ns=%b ew=%b cd=%0d ph=%0d want ns=%b ew=%b cd=%0d ph=%0d",
               nm, $time, a.ns, a.ew, a.cd, a.ph,
               e.ns, e.ew, e.cd, e.ph);
    end
  endtask

  task automatic step(bit r, logic [1:0] p, bit f);
    exp_t e;
    rst = r; ped_req = p; flash_en = f;
    model_step(r, p, f);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp("cycle", dut_out(), e);
    checks++;
    if (ns_rgy[0] === 1'b1 && ew_rgy[0] === 1'b1) begin
      errors++;
      $display("FAIL green_conflict t=%0t: got ns=%b ew=%b want no double green",
               $time, ns_rgy, ew_rgy);
    end
  endtask

  initial begin
    rst = 1'b1; ped_req = 2'b00; flash_en = 1'b0;
    tv.push_back(mk("reset",      1, 0, 0,  1, G, R, 60, NS_GREEN));
    tv.push_back(mk("ns_g_end",   0, 0, 0, 59, G, R,  1, NS_GREEN));
    tv.push_back(mk("ns_y",       0, 0, 0,  1, Y, R,  5, NS_YELLOW));
    tv.push_back(mk("allred_a",   0, 0, 0,  5, R, R,  2, ALLRED_A));
    tv.push_back(mk("ew_g",       0, 0, 0,  2, R, G, 60, EW_GREEN));
    tv.push_back(mk("ew_y",       0, 0, 0, 60, R, Y,  5, EW_YELLOW));
    tv.push_back(mk("allred_b",   0, 0, 0,  5, R, R,  2, ALLRED_B));
    tv.push_back(mk("cycle134",   0, 0, 0,  2, G, R, 60, NS_GREEN));
    tv.push_back(mk("ns40",       0, 0, 0, 20, G, R, 40, NS_GREEN));
    tv.push_back(mk("ped_ns",     0, 1, 0,  1, G, R, 10, NS_GREEN));
    tv.push_back(mk("ped_ns_y",   0, 0, 0, 10, Y, R,  5, NS_YELLOW));
    tv.push_back(mk("ped_ew_y",   0, 2, 0,  1, Y, R,  4, NS_YELLOW));
    tv.push_back(mk("ew_short",   0, 0, 0,  6, R, G, 10, EW_GREEN));
    tv.push_back(mk("ns_after",   0, 0, 0, 17, G, R, 60, NS_GREEN));
    tv.push_back(mk("pend_clr",   0, 0, 0, 67, R, G, 60, EW_GREEN));
    tv.push_back(mk("flash_on",   0, 0, 1,  4, Y, Y,  0, FLASH));
    tv.push_back(mk("flash_off",  0, 0, 1,  1, O, O,  0, FLASH));
    tv.push_back(mk("flash_on2",  0, 0, 1, 15, Y, Y,  0, FLASH));
    tv.push_back(mk("flash_rel",  0, 0, 0,  1, R, R,  2, ALLRED_B));
    tv.push_back(mk("rel_1",      0, 0, 0,  1, R, R,  1, ALLRED_B));
    tv.push_back(mk("rel_ns",     0, 0, 0,  1, G, R, 60, NS_GREEN));
    tv.push_back(mk("ns7",        0, 0, 0, 53, G, R,  7, NS_GREEN));
    tv.push_back(mk("ped_late",   0, 1, 0,  1, G, R,  6, NS_GREEN));
    tv.push_back(mk("late_y",     0, 0, 0,  6, Y, R,  5, NS_YELLOW));
    tv.push_back(mk("ar_last",    0, 0, 0,  6, R, R,  1, ALLRED_A));
    tv.push_back(mk("same_edge",  0, 2, 0,  1, R, G, 10, EW_GREEN));
    tv.push_back(mk("ew_y2",      0, 0, 0, 10, R, Y,  5, EW_YELLOW));
    tv.push_back(mk("ew_y3",      0, 0, 0,  2, R, Y,  3, EW_YELLOW));
    tv.push_back(mk("rst_ew_y",   1, 0, 0,  1, G, R, 60, NS_GREEN));
    tv.push_back(mk("flash2",     0, 0, 1,  3, Y, Y,  0, FLASH));
    tv.push_back(mk("rst_flash",  1, 3, 1,  1, G, R, 60, NS_GREEN));
    tv.push_back(mk("pend_set",   0, 2, 0,  1, G, R, 59, NS_GREEN));
    tv.push_back(mk("flash3",     0, 0, 1,  2, Y, Y,  0, FLASH));
    tv.push_back(mk("rel3",       0, 0, 0,  1, R, R,  2, ALLRED_B));
    tv.push_back(mk("ns3",        0, 0, 0,  2, G, R, 60, NS_GREEN));
    tv.push_back(mk("pend_flush", 0, 0, 0, 67, R, G, 60, EW_GREEN));
    tv.push_back(mk("both_ped",   0, 3, 0,  1, R, G, 10, EW_GREEN));
    tv.push_back(mk("both_ew_y",  0, 0, 0, 10, R, Y,  5, EW_YELLOW));
    tv.push_back(mk("both_ns",    0, 0, 0,  7, G, R, 10, NS_GREEN));
    tv.push_back(mk("ns_last",    0, 0, 0,  9, G, R,  1, NS_GREEN));
    tv.push_back(mk("flash_prio", 0, 1, 1,  1, Y, Y,  0, FLASH));
    tv.push_back(mk("prio_rel",   0, 0, 0,  1, R, R,  2, ALLRED_B));

    foreach (tv[i]) begin
      for (int k = 0; k < tv[i].n; k++)
        step(tv[i].r, tv[i].p, tv[i].f);
      cmp(tv[i].name, dut_out(), tv[i].e);
    end

    // hand sequence: countdown walk after reset, then flash pattern
    step(1, 0, 0);
    for (int k = 0; k < 67; k++) begin
      exp_t e;
      e.ph = (k < 60) ? NS_GREEN : (k < 65) ? NS_YELLOW : ALLRED_A;
      e.cd = (k < 60) ? 60 - k : (k < 65) ? 65 - k : 67 - k;
      e.ns = (k < 60) ? G : (k < 65) ? Y : R;
      e.ew = R;
      cmp("walk", dut_out(), e);
      step(0, 0, 0);
    end
    for (int k = 0; k < 12; k++) begin
      exp_t e;
      step(0, 0, 1);
      e.ns = (k < 4 || k >= 8) ? Y : O;
      e.ew = e.ns; e.cd = 0; e.ph = FLASH;
      cmp("flash_walk", dut_out(), e);
    end
    step(1, 0, 1);
    cmp("rst_mid_flash", dut_out(), '{G, R, 60, NS_GREEN});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_light.md
INTERSECTION_LIGHT -- requirements
Module: intersection_light

Interface
REQ-001 Parameter GREEN_LEN, default 60: green phase length in cycles, legal range >=2.
REQ-002 Parameter YELLOW_LEN, default 5: yellow phase length in cycles, legal range >=1.
REQ-003 Parameter ALLRED_LEN, default 2: all-red clearance length in cycles, legal range >=1.
REQ-004 Parameter PED_MAX, default 10: maximum green remaining after a pedestrian request, legal range 1 <= PED_MAX < GREEN_LEN.
REQ-005 Parameter FLASH_HALF, default 4: cycles per flash half-period, legal range >=1.
REQ-006 Parameter CNT_W, default 8: countdown width, required to hold max(GREEN_LEN, YELLOW_LEN, ALLRED_LEN).
REQ-007 clk  input  1  single clock; all logic updates on the rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 ped_req  input  2  pedestrian request; bit0 shortens NS green, bit1 shortens EW green; level-sampled every cycle.
REQ-010 flash_en  input  1  maintenance flash mode, level-sensitive.
REQ-011 ns_rgy  output  3  NS lamps {red, yellow, green}, one-hot or all-zero.
REQ-012 ew_rgy  output  3  EW lamps {red, yellow, green}, one-hot or all-zero.
REQ-013 countdown  output  CNT_W  cycles remaining in the current phase, including the present cycle.
REQ-014 phase  output  3  current phase encoding, for observability.

Function
REQ-015 Phases cycle in this order: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN. A separate FLASH phase exists outside this cycle.
REQ-016 Lamp decode: the active direction shows green or yellow and the other direction shows red; both directions show red in ALLRED_A/B.
REQ-017 Outputs shall be decoded directly from the phase and counter registers, with no additional register stage; countdown equals the remaining-cycle register.
REQ-018 Each cycle outside FLASH, if remaining > 1 then remaining decrements; if remaining == 1 then the next phase is entered with remaining loaded with that phase's length.
REQ-019 ped_req[d] asserted during d's green with remaining > PED_MAX: remaining <= PED_MAX on the next edge, replacing the decrement.
REQ-020 ped_req[d] asserted during d's green with remaining <= PED_MAX: normal decrement, no effect.
REQ-021 ped_req[d] asserted in any other non-FLASH phase: sets pend[d].
REQ-022 pend[d] set on entry to d's green: green is loaded with PED_MAX instead of GREEN_LEN, and pend[d] is cleared.
REQ-023 Both ped_req bits asserted together: each bit is handled independently per REQ-019 to REQ-022.
REQ-024 A request arriving on the same edge as entry to its green shall be honoured: that green loads PED_MAX.
REQ-025 flash_en sampled high in any phase: the next state is FLASH.
REQ-026 In FLASH: red and green are off in both directions; both yellow lamps toggle together every FLASH_HALF cycles, starting on; countdown = 0; pend is cleared; ped_req is ignored.
REQ-027 flash_en sampled low while in FLASH: the next phase is ALLRED_B with remaining = ALLRED_LEN.
REQ-028 flash_en has priority over phase expiry and over ped_req on the same edge.
REQ-029 Green shall never be active in both directions, and never in any phase transition.

Reset
REQ-030 rst high at an edge shall apply the following values: phase = NS_GREEN, remaining = GREEN_LEN, pend = 0, flash counter = 0.
REQ-031 Resulting outputs after reset: ns_rgy = 001, ew_rgy = 100, countdown = GREEN_LEN.
REQ-032 rst shall have priority over flash_en and ped_req, and shall take effect mid-phase or mid-flash.

Structure
REQ-033 A shared package traffic_pkg shall hold the phase enumeration type, the lamp-vector constants and a phase-length function.
REQ-034 The design shall contain one sub-module, flash_gen: a FLASH_HALF toggle counter with enable and synchronous clear.
REQ-035 Elaboration-time assertions shall reject parameter values outside the legal ranges in REQ-001 to REQ-006.

Verification
REQ-036 Reset release, default parameters -> countdown reads 60..1, then NS_YELLOW 5..1, ALLRED_A 2..1, then EW_GREEN 60; full cycle = 134 cycles.
REQ-037 ped_req = 01 pulsed at NS countdown 40 -> next cycle countdown = 10, NS_YELLOW entered 10 cycles later.
REQ-038 ped_req = 10 pulsed during NS_YELLOW -> EW_GREEN loads 10 instead of 60, and pend[1] is clear afterwards.
REQ-039 ped_req = 01 pulsed at NS countdown 7 -> no change; yellow follows at countdown expiry.
REQ-040 flash_en high for 20 cycles in EW_GREEN -> yellows go on 4 / off 4 / on 4 ..., countdown = 0; after release, ALLRED_B 2,1, then NS_GREEN 60.
REQ-041 rst asserted mid-EW_YELLOW, and separately during FLASH -> next cycle ns_rgy = 001, ew_rgy = 100, countdown = 60; a scoreboard checks that both greens are never active together.
